mux8_rr_scheduler: RTL

- Round-robin scheduler that shares one 8:1 single-bit mux output channel among 8 requesters.
- Arbitrates `req[7:0]` and drives the mux selects `s2,s1,s0` with the winner's index.
- Runs a valid/ready handshake toward the consumer of the mux output `y`.
- Bounds each grant to HOLD_MAX transfers so no requester can starve the others.

---
 rtl/mux8_rr_scheduler.sv | 86 ++++++++
 1 files changed

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler that drives the selects of a shared 8:1 mux and handshakes its output.
// Each grant is capped at HOLD_MAX accepted transfers, and consecutive grants are separated by one idle cycle.
module mux8_rr_scheduler #(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    req,
  input  logic          out_ready,
  output logic          s2,
  output logic          s1,
  output logic          s0,
  output logic [7:0]    gnt,
  output logic          out_valid,
  output logic [CW-1:0] xfer_cnt
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        r_state;
  logic [2:0]    r_ptr;
  logic [2:0]    r_sel;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_gnt;

  logic [2:0]    w_win;
  logic          w_valid;
  logic          w_xfer;
  logic          w_last;
  logic          w_release;

  // The scan runs downward, so the nearest set bit at or after r_ptr is assigned last and wins.
  always_comb begin
    w_win = r_ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[r_ptr + 3'(i)]) w_win = r_ptr + 3'(i);
    end
  end

  always_comb begin
    w_valid   = (r_state == StGrant) && req[r_sel];
    w_xfer    = w_valid && out_ready;
    w_last    = (r_cnt == CW'(HOLD_MAX - 1));
    w_release = (r_state == StGrant) && (!req[r_sel] || (w_xfer && w_last));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|req) begin
            r_sel   <= w_win;
            r_gnt   <= 8'd1 << w_win;
            r_cnt   <= '0;
            r_state <= StGrant;
          end
        end
        StGrant: begin
          if (w_release) begin
            // r_sel is left unchanged here so the mux selects stay stable while idle.
            r_state <= StIdle;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_ptr   <= r_sel + 3'd1;
          end else if (w_xfer) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign {s2, s1, s0} = r_sel;
  assign gnt          = r_gnt;
  assign out_valid    = w_valid;
  assign xfer_cnt     = r_cnt;

endmodule
